// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter: round-robin share of the single ALU operand mux.
// Grants one core at a time, drives the mux, returns its result with ack.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req           per-core request, held until that core's ack
//   req_sel       per-core 3-bit select code, core i at [3i+2:3i]
//   req_data      per-core raw operand, core i at slice i
//   ack           one-hot, one-cycle completion pulse
//   rsp_data      mux result returned with ack, held until next ack
//   busy          high whenever the FSM is not in IDLE
//   grant_idx     core currently or last served
//   mux_enable    mux enable input
//   mux_select    mux select input
//   mux_data      mux data_in input
//   mux_result    mux data_out
module alu_operand_arbiter #(
  parameter int NUM_CORES = 8,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [3*NUM_CORES-1:0]      req_sel,
  input  logic [DATA_W*NUM_CORES-1:0] req_data,
  output logic [NUM_CORES-1:0]        ack,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        mux_enable,
  output logic [2:0]                  mux_select,
  output logic [DATA_W-1:0]           mux_data,
  input  logic [DATA_W-1:0]           mux_result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]      rsp_q, rsp_d;
  logic                   busy_q, busy_d;
  logic                   en_q, en_d;
  logic [2:0]             sel_q, sel_d;
  logic [DATA_W-1:0]      data_q, data_d;

  logic                   found;
  int                     win;
  logic [IDX_W-1:0]       gidx_nxt;

  // Rotating scan: first requester at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!found && req[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
  end

  always_comb begin
    if (gidx_q == IDX_W'(NUM_CORES - 1)) gidx_nxt = '0;
    else                                 gidx_nxt = gidx_q + 1'b1;
  end

  // Outputs are computed from the next state so that each
  // registered output is valid during the state it belongs to.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    ack_d   = '0;
    rsp_d   = rsp_q;
    en_d    = 1'b0;
    sel_d   = sel_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          gidx_d  = IDX_W'(win);
          sel_d   = req_sel[3*win +: 3];
          data_d  = req_data[DATA_W*win +: DATA_W];
          en_d    = 1'b1;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
        en_d    = 1'b1;
      end
      CAPTURE: begin
        state_d = DONE;
        rsp_d   = mux_result;
        ack_d   = NUM_CORES'(1) << gidx_q;
        ptr_d   = gidx_nxt;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      ack_q   <= '0;
      rsp_q   <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign ack        = ack_q;
  assign rsp_data   = rsp_q;
  assign busy       = busy_q;
  assign grant_idx  = gidx_q;
  assign mux_enable = en_q;
  assign mux_select = sel_q;
  assign mux_data   = data_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// tb_alu_operand_arbiter: directed and random tests of the arbiter
// against a transaction-level model and a behavioural ALU mux.
module tb_alu_operand_arbiter;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [3*N-1:0]  req_sel;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_data;
  logic            busy;
  logic [IW-1:0]   grant_idx;
  logic            mux_enable;
  logic [2:0]      mux_select;
  logic [DW-1:0]   mux_data;
  logic [DW-1:0]   mux_result;

  int checks = 0;
  int errors = 0;

  alu_operand_arbiter #(.NUM_CORES(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel),
    .req_data(req_data), .ack(ack), .rsp_data(rsp_data),
    .busy(busy), .grant_idx(grant_idx), .mux_enable(mux_enable),
    .mux_select(mux_select), .mux_data(mux_data),
    .mux_result(mux_result)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mux_f(input logic [2:0] s,
                                          input logic [DW-1:0] d);
    case (s)
      3'd1:    return 16'hFFFF;
      3'd2:    return 16'h0001;
      3'd3:    return 16'h0004;
      3'd4:    return 16'h0008;
      default: return d;
    endcase
  endfunction

  assign mux_result = mux_enable ? mux_f(mux_select, mux_data) : '0;

  // Transaction-level model: a grant made in an idle cycle g
  // occupies g+1..g+3 and acks in g+3; the arbiter is free again at g+4.
  int            cyc = 0;
  int            free_at = 0;
  int            g_m = -100;
  int            ack_at = -1;
  int            ack_core = 0;
  int            ptr_m = 0;
  logic [DW-1:0] pend_rsp;
  logic [N-1:0]  exp_ack = '0;
  logic [DW-1:0] exp_rsp = '0;
  logic          exp_busy = 1'b0;
  logic          exp_en = 1'b0;
  int            exp_gidx = 0;
  logic [2:0]    exp_sel = '0;
  logic [DW-1:0] exp_data = '0;
  logic [47:0]   got, want;

  task automatic advance();
    int w;
    if (rst) begin
      ptr_m = 0; g_m = -100; ack_at = -1; free_at = cyc + 1;
      exp_rsp = '0; exp_gidx = 0; exp_sel = '0; exp_data = '0;
    end else if (cyc >= free_at && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      g_m = cyc; ack_at = cyc + 3; free_at = cyc + 4; ack_core = w;
      exp_gidx = w;
      exp_sel  = req_sel[3*w +: 3];
      exp_data = req_data[DW*w +: DW];
      pend_rsp = mux_f(exp_sel, exp_data);
      ptr_m    = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_ack = (cyc == ack_at) ? N'(1) << ack_core : '0;
    if (cyc == ack_at) exp_rsp = pend_rsp;
    exp_busy = (cyc > g_m) && (cyc <= g_m + 3);
    exp_en   = (cyc == g_m + 1) || (cyc == g_m + 2);
    got  = {ack, rsp_data, busy, grant_idx, mux_enable,
            mux_select, mux_data};
    want = {exp_ack, exp_rsp, exp_busy, IW'(exp_gidx), exp_en,
            exp_sel, exp_data};
  endtask

  task automatic post(input int i, input logic [2:0] s,
                      input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_sel[3*i +: 3] = s;
    req_data[DW*i +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) advance();
    checks++;
    if (got !== 48'h0) begin
      errors++;
      $display("FAIL reset got=%h want=0", got);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    repeat (2) advance();
    post(3, 3'd3, 16'h1234);
    for (int c = 1; c <= 4; c++) begin
      advance();
      checks++;
      if (c <= 2 && (mux_select !== 3'd3 || mux_enable !== 1'b1
                     || busy !== 1'b1 || ack !== '0)) begin
        errors++;
        $display("FAIL single_c%0d sel=%0d en=%b busy=%b want 3/1/1",
                 c, mux_select, mux_enable, busy);
      end
      if (c == 3 && (ack !== 8'h08 || rsp_data !== 16'h0004)) begin
        errors++;
        $display("FAIL single_ack ack=%h rsp=%h want 08/0004",
                 ack, rsp_data);
      end
      if (c == 4 && (busy !== 1'b0 || ack !== '0)) begin
        errors++;
        $display("FAIL single_idle busy=%b ack=%h want 0/00", busy, ack);
      end
      if (c == 3) req[3] = 1'b0;
    end
  endtask

  task automatic test_passthrough();
    logic [2:0]    sels [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic [DW-1:0] exps [4] = '{16'hBEEF, 16'hFFFF, 16'h0001, 16'h0008};
    for (int t = 0; t < 4; t++) begin
      post(0, sels[t], 16'hBEEF);
      repeat (3) advance();
      checks++;
      if (ack !== 8'h01 || rsp_data !== exps[t]) begin
        errors++;
        $display("FAIL pass_sel%0d ack=%h rsp=%h want 01/%h",
                 sels[t], ack, rsp_data, exps[t]);
      end
      req[0] = 1'b0;
      advance();
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    int last = 0;
    int who;
    rst = 1'b1;
    repeat (2) advance();
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      post(i, 3'($urandom_range(0, 7)), 16'($urandom));
    for (int t = 0; t < 60 && n < 9; t++) begin
      advance();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rr_cyc%0d got=%h want=%h", cyc, got, want);
      end
      if (ack != '0) begin
        who = -1;
        for (int i = 0; i < N; i++) if (ack[i]) who = i;
        checks++;
        if (who != n % N || (n > 0 && cyc - last != 4)) begin
          errors++;
          $display("FAIL rr_order n=%0d core=%0d gap=%0d want %0d/4",
                   n, who, cyc - last, n % N);
        end
        last = cyc;
        n++;
      end
    end
    req = '0;
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL rr_count acks=%0d want 9", n);
    end
  endtask

  task automatic test_ptr_wrap();
    int order [2] = '{-1, -1};
    int n = 0;
    repeat (2) advance();
    post(7, 3'd5, 16'h7777);
    for (int t = 0; t < 12 && !ack[7]; t++) advance();
    req[7] = 1'b0;
    advance();
    post(2, 3'd6, 16'h2222);
    post(6, 3'd7, 16'h6666);
    for (int t = 0; t < 20 && n < 2; t++) begin
      advance();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL wrap_cyc%0d got=%h want=%h", cyc, got, want);
      end
      for (int i = 0; i < N; i++)
        if (ack[i]) begin
          order[n] = i;
          n++;
          req[i] = 1'b0;
        end
    end
    checks++;
    if (order[0] != 2 || order[1] != 6) begin
      errors++;
      $display("FAIL wrap_order got=%0d,%0d want 2,6", order[0], order[1]);
    end
  endtask

  task automatic test_reset_mid();
    int k = -1;
    repeat (2) advance();
    post(5, 3'd2, 16'h5555);
    repeat (2) advance();
    rst = 1'b1;
    advance();
    checks++;
    if (got !== 48'h0) begin
      errors++;
      $display("FAIL rstmid_zero got=%h want=0", got);
    end
    rst = 1'b0;
    for (int t = 1; t <= 8 && k < 0; t++) begin
      advance();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rstmid_cyc%0d got=%h want=%h", cyc, got, want);
      end
      if (ack != '0) begin
        k = t;
        req[5] = 1'b0;
      end
    end
    checks++;
    if (k != 3 || exp_ack !== 8'h20) begin
      errors++;
      $display("FAIL rstmid_lat got=%0d want 3", k);
    end
  endtask

  task automatic test_early_drop();
    repeat (2) advance();
    post(1, 3'd4, 16'h0101);
    advance();
    req[1] = 1'b0;
    repeat (2) advance();
    checks++;
    if (ack !== 8'h02 || rsp_data !== 16'h0008) begin
      errors++;
      $display("FAIL early_ack ack=%h rsp=%h want 02/0008", ack, rsp_data);
    end
    for (int t = 0; t < 4; t++) begin
      advance();
      checks++;
      if (busy !== 1'b0 || ack !== '0 || mux_enable !== 1'b0) begin
        errors++;
        $display("FAIL early_regrant busy=%b ack=%h want 0/00", busy, ack);
      end
    end
  endtask

  task automatic test_random();
    int wait_c [N];
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    for (int t = 0; t < 800; t++) begin
      advance();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rand_cyc%0d got=%h want=%h", cyc, got, want);
      end
      for (int i = 0; i < N; i++) begin
        if (req[i]) wait_c[i]++;
        if (exp_ack[i]) begin
          checks++;
          if (wait_c[i] > 4 * N + 4) begin
            errors++;
            $display("FAIL rand_fair core=%0d wait=%0d max=%0d",
                     i, wait_c[i], 4 * N + 4);
          end
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          post(i, 3'($urandom_range(0, 7)), 16'($urandom));
          wait_c[i] = 0;
        end
      end
    end
    req = '0;
    repeat (4) advance();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_sel = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_passthrough();
    test_round_robin();
    test_ptr_wrap();
    test_reset_mid();
    test_early_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_arbiter.md
# alu_operand_arbiter

Round-robin arbiter that shares the single ALU operand-source mux among the processor cores. Each core posts an operand request (select code plus raw data). The arbiter grants one core at a time and drives the mux's select/enable/data inputs. It then samples the mux result and returns it to the granted core with a one-cycle acknowledge. It sits between the per-core execution control and the shared ALU_mux instance.

## Interface
- NUM_CORES, 8, number of requesting cores (2..16)
- DATA_W, 16, operand width; must match the mux data width
- IDX_W, $clog2(NUM_CORES), grant index width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NUM_CORES  per-core request; held high until that core's ack
- req_sel  input  3*NUM_CORES  per-core select code; core i uses bits [3i+2:3i]
- req_data  input  DATA_W*NUM_CORES  per-core raw operand; core i uses slice i
- ack  output  NUM_CORES  one-hot, one-cycle completion pulse
- rsp_data  output  DATA_W  operand returned with ack; holds until next ack
- busy  output  1  high in any state other than IDLE
- grant_idx  output  IDX_W  index of the core currently or last served
- mux_enable  output  1  drives the mux enable input
- mux_select  output  3  drives the mux select input
- mux_data  output  DATA_W  drives the mux data_in input
- mux_result  input  DATA_W  mux data_out

## Operation
- All outputs are registered.
- Reset values: ack=0, rsp_data=0, busy=0, grant_idx=0, mux_enable=0, mux_select=0, mux_data=0, round-robin pointer ptr=0, state=IDLE.
- FSM states: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from ptr upward, wrapping modulo NUM_CORES.
  - Latch that core's index into grant_idx, and its sel/data into mux_select/mux_data.
  - Go to ISSUE.
  - If req is zero, stay in IDLE with mux_enable=0.
- ISSUE: set mux_enable=1; go to CAPTURE.
- CAPTURE:
  - mux_enable stays 1.
  - At the end of this cycle, register mux_result into rsp_data and set ack[grant_idx]=1.
  - Set ptr=(grant_idx+1) mod NUM_CORES.
  - Go to DONE.
- DONE:
  - ack is high for exactly this cycle.
  - Clear mux_enable; go to IDLE.
- Select codes are forwarded unchanged, including 5-7; the mux treats these as pass-through.
- The arbiter does not range-check or modify operands.
- mux_select/mux_data hold their last latched value outside ISSUE/CAPTURE.
- If a core drops req before its ack, the transaction still completes and ack still pulses.
- Requests arriving during ISSUE, CAPTURE or DONE wait; they are arbitrated only in IDLE.
- Fairness: a continuously requesting core is served within NUM_CORES transactions.
- Reset mid-transaction:
  - Aborts immediately to IDLE with all reset values.
  - No ack is issued for the aborted grant.
  - Still-held requests are re-arbitrated from ptr=0.

## Timing
- Request-to-ack latency with the arbiter idle: req high in cycle 0 (IDLE), ISSUE in cycle 1, CAPTURE in cycle 2, ack and rsp_data valid in cycle 3.
- Throughput: one transaction per 4 cycles; back-to-back grants with no idle gap when req stays nonzero.
- The mux sees stable select/data/enable for 2 full cycles (ISSUE, CAPTURE) before its result is sampled.
- Core rule: drop req at the clock edge ending the ack cycle. The arbiter samples req in the following IDLE cycle, so a core that follows this rule is never double-served.
- busy=1 from cycle 1 through cycle 3 of each transaction.

## Test plan
- Single request:
  - Stimulus: core 3 with sel=3, data=0x1234.
  - Response: mux_select=3 and mux_enable=1 in cycles 1-2; ack[3]=1 in cycle 3 with rsp_data=0x0004 (mux output); busy low in cycle 4.
- Pass-through and constants:
  - Stimulus: core 0 issues sel=0/data=0xBEEF, then sel=1, sel=2, sel=4.
  - Response: rsp_data = 0xBEEF, 0xFFFF, 0x0001, 0x0008 respectively.
- Round-robin:
  - Stimulus: all 8 cores request continuously after reset.
  - Response: acks in order 0,1,...,7,0; each ack exactly 4 cycles apart; no core served twice before all others.
- Pointer wrap:
  - Stimulus: core 7 served, then cores 2 and 6 request together.
  - Response: core 2 granted first (scan wraps from ptr=0), then core 6.
- Reset mid-operation:
  - Stimulus: assert rst during CAPTURE for core 5.
  - Response: no ack; all outputs 0 next cycle; with req[5] still high after rst drops, ack[5] arrives 3 cycles after the first IDLE cycle.
- Early drop:
  - Stimulus: core 1 deasserts req in ISSUE.
  - Response: ack[1] still pulses in cycle 3; the next IDLE does not re-grant core 1.
